// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM command-port arbiter: port tags,
// FSM encoding and default bus widths.
package sdram_arb_pkg;

  localparam int DEF_AW = 24;
  localparam int DEF_DW = 16;

  // Tag stored per outstanding read so return data finds its requester.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Requester ports A/B plus the controller write/read channels, bundled.
// slave: the arbiter's view. master: the view of whatever drives it.
interface sdram_port_arbiter_if
  import sdram_arb_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) ();

  logic          a_valid, a_we, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;

  logic          b_valid, b_we, b_ready, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;

  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;
  logic          wvalid, wready, arvalid, arready, rvalid;

  modport slave (
    input  a_valid, a_we, a_addr, a_wdata,
    output a_ready, a_rdata, a_rvalid,
    input  b_valid, b_we, b_addr, b_wdata,
    output b_ready, b_rdata, b_rvalid,
    output awaddr, wdata, wvalid,
    input  wready,
    output araddr, arvalid,
    input  arready, rdata, rvalid
  );

  modport master (
    output a_valid, a_we, a_addr, a_wdata,
    input  a_ready, a_rdata, a_rvalid,
    output b_valid, b_we, b_addr, b_wdata,
    input  b_ready, b_rdata, b_rvalid,
    input  awaddr, wdata, wvalid,
    output wready,
    input  araddr, arvalid,
    output arready, rdata, rvalid
  );

endinterface

// File: rtl/tag_fifo.sv
// DEPTH x 1-bit FIFO of port tags for outstanding reads, in issue order.
module tag_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          push_tag,
  input  logic          pop,
  output logic          head_tag,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign head_tag = mem[rd_ptr];

  // Tag storage write.
  // NOTE: storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_tag;
  end

  // Pointers and occupancy; power-of-two depth lets pointers wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-requester arbiter in front of the SDRAM controller command port.
// One command in flight on the command channels; read data is routed
// back in order using a tag FIFO; B is protected from starvation by A.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW           = DEF_AW,
  parameter int DW           = DEF_DW,
  parameter int RD_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  sdram_port_arbiter_if.slave  bus,
  output logic                 busy,
  output logic                 rsp_error
);

  localparam int CW = $clog2(RD_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  state_t        state, next_state;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_we;
  logic [SW-1:0] starve_cnt;

  logic          a_elig, b_elig, grant, accept;
  logic          a_ready, b_ready;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  logic          fifo_full, fifo_empty, head_tag, fifo_pop;
  logic [CW-1:0] fifo_count;

  // Grant, ready and next state; a port is eligible only if it can be
  // taken now, so a read stuck on a full FIFO lets the other port's write in.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    a_ready    = 1'b0;
    b_ready    = 1'b0;
    a_elig     = bus.a_valid && (bus.a_we || !fifo_full);
    b_elig     = bus.b_valid && (bus.b_we || !fifo_full);
    grant      = PORT_A;
    if (b_elig && (!a_elig || (starve_cnt == SW'(STARVE_LIMIT)))) grant = PORT_B;
    acc_we     = (grant == PORT_A) ? bus.a_we    : bus.b_we;
    acc_addr   = (grant == PORT_A) ? bus.a_addr  : bus.b_addr;
    acc_wdata  = (grant == PORT_A) ? bus.a_wdata : bus.b_wdata;
    unique case (state)
      IDLE: begin
        a_ready = !rst && (grant == PORT_A) && a_elig;
        b_ready = !rst && (grant == PORT_B) && b_elig;
        if (a_ready || b_ready) next_state = ISSUE;
      end
      ISSUE: if (cmd_we ? bus.wready : bus.arready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    accept = a_ready || b_ready;
  end

  // State and command latch; the command holds until the controller takes it.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_we    <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        cmd_addr  <= acc_addr;
        cmd_wdata <= acc_wdata;
        cmd_we    <= acc_we;
      end
    end
  end

  // Count A wins while B waits; a B win or an idle cycle without B clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (accept && (grant == PORT_A) && bus.b_valid) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
    end else if ((accept && (grant == PORT_B)) || ((state == IDLE) && !bus.b_valid)) begin
      starve_cnt <= '0;
    end
  end

  // Sticky flag for return data that no read was waiting for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           rsp_error <= 1'b0;
    else if (bus.rvalid && fifo_empty) rsp_error <= 1'b1;
  end

  assign fifo_pop = bus.rvalid && !fifo_empty;

  tag_fifo #(.DEPTH(RD_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (accept && !acc_we),
    .push_tag (grant),
    .pop      (fifo_pop),
    .head_tag (head_tag),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign bus.a_ready  = a_ready;
  assign bus.b_ready  = b_ready;
  assign bus.wvalid   = (state == ISSUE) && cmd_we;
  assign bus.arvalid  = (state == ISSUE) && !cmd_we;
  assign bus.awaddr   = cmd_addr;
  assign bus.araddr   = cmd_addr;
  assign bus.wdata    = cmd_wdata;
  assign bus.a_rdata  = bus.rdata;
  assign bus.b_rdata  = bus.rdata;
  assign bus.a_rvalid = fifo_pop && (head_tag == PORT_A);
  assign bus.b_rvalid = fifo_pop && (head_tag == PORT_B);
  assign busy         = (state != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: a table of single commands plus hand-built
// sequences for backpressure, starvation, a full tag FIFO, reset and a
// spurious return. A negedge monitor scoreboards issued commands and
// read-data routing against what the bench drove.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam int AW = 24;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  logic busy, rsp_error;

  sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sdram_port_arbiter #(.AW(AW), .DW(DW), .RD_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .rsp_error (rsp_error)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  cmd_t cmd_q[$];
  logic rd_q[$];
  logic grants[$];
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic port, input logic v, input logic we,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (port == PORT_A) begin
      bus.a_valid = v; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = data;
    end else begin
      bus.b_valid = v; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = data;
    end
  endtask

  // Raise a request, wait (bounded) for ready, drop it after the accept edge.
  task automatic do_cmd(input logic port, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat);
    set_req(port, 1'b1, we, addr, data);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((port == PORT_A) ? bus.a_ready : bus.b_ready) begin
        lat = i;
        break;
      end
      tick();
    end
    if (lat < 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL ready_timeout: port %0d got no ready within 20 cycles", port);
    end
    tick();
    set_req(port, 1'b0, we, addr, data);
  endtask

  // Scoreboard monitor: pop expectations on controller handshakes and
  // return data, then push new ones for commands accepted this cycle.
  always @(negedge clk) begin
    cmd_t c;
    logic p;
    if (!rst) begin
      if (bus.wvalid && bus.wready) begin
        if (cmd_q.size() == 0) check("unexpected_write", 32'(bus.wvalid), 32'd0);
        else begin
          c = cmd_q.pop_front();
          check("issue_is_write", 32'(bus.wvalid), 32'(c.we));
          check("awaddr", 32'(bus.awaddr), 32'(c.addr));
          check("wdata", 32'(bus.wdata), 32'(c.data));
        end
      end
      if (bus.arvalid && bus.arready) begin
        if (cmd_q.size() == 0) check("unexpected_read", 32'(bus.arvalid), 32'd0);
        else begin
          c = cmd_q.pop_front();
          check("issue_is_read", 32'(bus.arvalid), 32'(!c.we));
          check("araddr", 32'(bus.araddr), 32'(c.addr));
        end
      end
      if (bus.rvalid) begin
        if (rd_q.size() == 0) begin
          check("stray_a_rvalid", 32'(bus.a_rvalid), 32'd0);
          check("stray_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        end else begin
          p = rd_q.pop_front();
          check("route_a_rvalid", 32'(bus.a_rvalid), 32'(p == PORT_A));
          check("route_b_rvalid", 32'(bus.b_rvalid), 32'(p == PORT_B));
          check("route_rdata", 32'((p == PORT_A) ? bus.a_rdata : bus.b_rdata), 32'(bus.rdata));
        end
      end
      if (bus.a_ready || bus.b_ready)
        check("one_grant", 32'(bus.a_ready && bus.b_ready), 32'd0);
      if (bus.a_valid && bus.a_ready) begin
        cmd_q.push_back('{bus.a_we, bus.a_addr, bus.a_wdata});
        if (!bus.a_we) rd_q.push_back(PORT_A);
      end
      if (bus.b_valid && bus.b_ready) begin
        cmd_q.push_back('{bus.b_we, bus.b_addr, bus.b_wdata});
        if (!bus.b_we) rd_q.push_back(PORT_B);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vecs[0] = '{PORT_A, 1'b1, 24'h000010, 16'hBEEF, 16'h0000};
    vecs[1] = '{PORT_B, 1'b1, 24'h000200, 16'h1234, 16'h0000};
    vecs[2] = '{PORT_A, 1'b0, 24'h000300, 16'h0000, 16'hA5A5};
    vecs[3] = '{PORT_B, 1'b0, 24'hFFFFFF, 16'h0000, 16'h0001};
    vecs[4] = '{PORT_A, 1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0000};
    vecs[5] = '{PORT_B, 1'b1, 24'h000000, 16'h0000, 16'h0000};

    // Reset with requests and a return pending: everything must read 0.
    rst = 1'b1;
    set_req(PORT_A, 1'b1, 1'b0, 24'h1, 16'h1);
    set_req(PORT_B, 1'b1, 1'b0, 24'h2, 16'h2);
    bus.wready = 1'b1; bus.arready = 1'b1; bus.rvalid = 1'b1; bus.rdata = 16'h0;
    @(negedge clk);
    check("rst_a_ready", 32'(bus.a_ready), 0);
    check("rst_b_ready", 32'(bus.b_ready), 0);
    check("rst_wvalid", 32'(bus.wvalid), 0);
    check("rst_arvalid", 32'(bus.arvalid), 0);
    check("rst_a_rvalid", 32'(bus.a_rvalid), 0);
    check("rst_b_rvalid", 32'(bus.b_rvalid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rsp_error", 32'(rsp_error), 0);
    set_req(PORT_A, 1'b0, 1'b0, 24'h0, 16'h0);
    set_req(PORT_B, 1'b0, 1'b0, 24'h0, 16'h0);
    bus.rvalid = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Table of single commands with the controller always ready.
    for (int i = 0; i < 6; i++) begin
      do_cmd(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      check($sformatf("vec%0d_ready_lat", i), 32'(lat), 0);
      @(negedge clk);
      check($sformatf("vec%0d_wvalid", i), 32'(bus.wvalid), 32'(vecs[i].we));
      check($sformatf("vec%0d_arvalid", i), 32'(bus.arvalid), 32'(!vecs[i].we));
      tick();
      @(negedge clk);
      check($sformatf("vec%0d_busy_n2", i), 32'(busy), 32'(!vecs[i].we));
      if (!vecs[i].we) begin
        tick();
        bus.rvalid = 1'b1;
        bus.rdata  = vecs[i].rdata;
        @(negedge clk);
        check($sformatf("vec%0d_rdata", i),
              32'((vecs[i].port == PORT_A) ? bus.a_rdata : bus.b_rdata), 32'(vecs[i].rdata));
        tick();
        bus.rvalid = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d_busy_done", i), 32'(busy), 0);
      end
      tick();
    end

    // Backpressure: B read held for 5 refused cycles while A waits.
    bus.arready = 1'b0;
    do_cmd(PORT_B, 1'b0, 24'h000123, 16'h0, lat);
    check("bp_ready_lat", 32'(lat), 0);
    set_req(PORT_A, 1'b1, 1'b1, 24'h000777, 16'h7777);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) bus.arready = 1'b1;
      @(negedge clk);
      check($sformatf("bp_arvalid_%0d", k), 32'(bus.arvalid), 1);
      check($sformatf("bp_araddr_%0d", k), 32'(bus.araddr), 32'h000123);
      check($sformatf("bp_no_grant_%0d", k), 32'(bus.a_ready), 0);
      tick();
    end
    set_req(PORT_A, 1'b0, 1'b1, 24'h000777, 16'h7777);
    bus.rvalid = 1'b1;
    bus.rdata  = 16'h5A5A;
    @(negedge clk);
    check("bp_b_rvalid", 32'(bus.b_rvalid), 1);
    check("bp_a_rvalid", 32'(bus.a_rvalid), 0);
    check("bp_b_rdata", 32'(bus.b_rdata), 32'h5A5A);
    tick();
    bus.rvalid = 1'b0;
    tick();

    // Starvation: both ports stream writes; expect 8 A grants then 1 B.
    set_req(PORT_A, 1'b1, 1'b1, 24'h00000A, 16'hAAAA);
    set_req(PORT_B, 1'b1, 1'b1, 24'h00000B, 16'hBBBB);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.a_ready) grants.push_back(PORT_A);
      if (bus.b_ready) grants.push_back(PORT_B);
      tick();
    end
    set_req(PORT_A, 1'b0, 1'b1, 24'h00000A, 16'hAAAA);
    set_req(PORT_B, 1'b0, 1'b1, 24'h00000B, 16'hBBBB);
    check("starve_grant_count_ok", 32'(grants.size() >= 18), 1);
    for (int i = 0; i < 18 && i < grants.size(); i++)
      check($sformatf("starve_grant_%0d", i), 32'(grants[i]), 32'((i % 9 == 8) ? PORT_B : PORT_A));
    tick();
    tick();

    // Four reads outstanding; the fifth waits, a B write slips past it.
    do_cmd(PORT_A, 1'b0, 24'h000100, 16'h0, lat);
    do_cmd(PORT_B, 1'b0, 24'h000101, 16'h0, lat);
    do_cmd(PORT_A, 1'b0, 24'h000102, 16'h0, lat);
    do_cmd(PORT_B, 1'b0, 24'h000103, 16'h0, lat);
    set_req(PORT_A, 1'b1, 1'b0, 24'h000104, 16'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("full_block_%0d", k), 32'(bus.a_ready), 0);
      tick();
    end
    set_req(PORT_B, 1'b1, 1'b1, 24'h000105, 16'hCAFE);
    @(negedge clk);
    check("write_bypass_b_ready", 32'(bus.b_ready), 1);
    check("write_bypass_a_ready", 32'(bus.a_ready), 0);
    tick();
    set_req(PORT_B, 1'b0, 1'b1, 24'h000105, 16'hCAFE);
    tick();
    bus.rvalid = 1'b1;
    bus.rdata  = 16'h1111;
    @(negedge clk);
    check("pop_no_free_a_ready", 32'(bus.a_ready), 0);
    check("pop1_a_rvalid", 32'(bus.a_rvalid), 1);
    tick();
    bus.rdata = 16'h2222;
    @(negedge clk);
    check("ready_after_pop", 32'(bus.a_ready), 1);
    check("pop2_b_rvalid", 32'(bus.b_rvalid), 1);
    tick();
    set_req(PORT_A, 1'b0, 1'b0, 24'h000104, 16'h0);
    bus.rdata = 16'h3333;
    tick();
    bus.rdata = 16'h4444;
    tick();
    bus.rdata = 16'h5555;
    tick();
    bus.rvalid = 1'b0;
    @(negedge clk);
    check("interleave_drained_busy", 32'(busy), 0);
    tick();

    // Reset during a held write with two reads outstanding.
    do_cmd(PORT_A, 1'b0, 24'h000200, 16'h0, lat);
    do_cmd(PORT_B, 1'b0, 24'h000201, 16'h0, lat);
    bus.wready = 1'b0;
    do_cmd(PORT_A, 1'b1, 24'h000202, 16'hD00D, lat);
    @(negedge clk);
    check("pre_rst_wvalid", 32'(bus.wvalid), 1);
    check("pre_rst_busy", 32'(busy), 1);
    #2;
    rst = 1'b1;
    set_req(PORT_A, 1'b1, 1'b1, 24'h000203, 16'h0);
    #1;
    check("mid_rst_wvalid", 32'(bus.wvalid), 0);
    check("mid_rst_arvalid", 32'(bus.arvalid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_a_ready", 32'(bus.a_ready), 0);
    check("mid_rst_awaddr", 32'(bus.awaddr), 0);
    check("mid_rst_wdata", 32'(bus.wdata), 0);
    cmd_q.delete();
    rd_q.delete();
    set_req(PORT_A, 1'b0, 1'b1, 24'h000203, 16'h0);
    bus.wready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_fifo_empty", 32'(busy), 0);
    tick();
    do_cmd(PORT_A, 1'b1, 24'h000300, 16'h1234, lat);
    check("post_rst_ready_lat", 32'(lat), 0);
    @(negedge clk);
    check("post_rst_wvalid", 32'(bus.wvalid), 1);
    tick();
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    tick();

    // Spurious return: nobody gets it, the error flag latches.
    bus.rvalid = 1'b1;
    bus.rdata  = 16'hDEAD;
    @(negedge clk);
    check("spur_a_rvalid", 32'(bus.a_rvalid), 0);
    check("spur_b_rvalid", 32'(bus.b_rvalid), 0);
    tick();
    bus.rvalid = 1'b0;
    @(negedge clk);
    check("spur_rsp_error", 32'(rsp_error), 1);
    tick();
    do_cmd(PORT_B, 1'b1, 24'h000400, 16'h4444, lat);
    tick();
    @(negedge clk);
    check("spur_rsp_error_sticky", 32'(rsp_error), 1);
    check("spur_no_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
